seq_detect_param: RTL and testbench

Parametrised, runtime-programmable serial pattern detector. It is the successor to the fixed 5-bit single-mode sequence detector. It adds:
- a PAT_W-bit pattern loaded at run time;
- an input qualifier;
- selectable overlapping or non-overlapping detection;
- a saturating match counter.

It sits on a serial bit stream and flags a match one cycle after the completing bit is sampled.

---
 rtl/seq_detect_param.sv | 132 +++++++++++++
 tb/tb_seq_detect_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Runtime-programmable serial pattern detector. A PAT_W-bit pattern is
// compared against the most recent qualified input bits. The first bit of the
// sequence is the pattern MSB, and newer bits shift in at the history LSB.
// A match raises outp for exactly one cycle, in the cycle after the edge that
// sampled the completing bit. A saturating counter tallies the matches.
//
// Parameters:
//   PAT_W   - pattern length in bits (2..32)
//   CNT_W   - match counter width
//   RST_PAT - pattern value after reset
//   RST_OVL - overlap mode after reset (1 = overlapping)
//
// Ports:
//   clk        - clock; all logic updates on the rising edge
//   rst        - synchronous active-high reset; overrides every other input
//   inp        - serial data bit
//   in_valid   - qualifies inp; inp is ignored while low
//   load       - one-cycle strobe: capture pattern/overlap_en, flush history
//   pattern    - new pattern, MSB = first bit of the sequence
//   overlap_en - new overlap mode, captured on load
//   clr_cnt    - synchronous clear of match_cnt (wins over an increment)
//   outp       - registered match pulse
//   match_cnt  - saturating count of matches
// ---------------------------------------------------------------------------
module seq_detect_param #(
  parameter int unsigned      PAT_W   = 5,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 5'b10110,
  parameter bit               RST_OVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             in_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             outp,
  output logic [CNT_W-1:0] match_cnt
);

  // The fill counter has to reach PAT_W, so it needs one more code than the
  // pattern width alone would suggest.
  localparam int unsigned      FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_GATE = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic              ovl_q,  ovl_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              outp_q, outp_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [PAT_W-1:0]  next_hist;
  logic              hit;

  // Next-state logic for detection. Load takes priority over data: it
  // discards that cycle's bit and empties the history. The fill gate makes
  // sure that the zeros left by a flush can never complete a match. Without
  // it, an all-zero pattern would fire on the first valid zero.
  always_comb begin
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    outp_d    = 1'b0;
    hit       = 1'b0;
    next_hist = {hist_q[PAT_W-2:0], inp};

    if (load) begin
      pat_d  = pattern;
      ovl_d  = overlap_en;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hit = (next_hist == pat_q) && (fill_q >= FILL_GATE);
      if (hit) begin
        outp_d = 1'b1;
        if (ovl_q) begin
          // Keep the matched bits so they can seed the next match.
          hist_d = next_hist;
          fill_d = FILL_FULL;
        end else begin
          // Non-overlap mode: the next match needs PAT_W fresh bits.
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = next_hist;
        fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
      end
    end
  end

  // Match counter. It saturates at all-ones. A clear in the same cycle as a
  // hit wins, so the counter reads zero afterwards.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= RST_PAT;
      ovl_q  <= RST_OVL;
      hist_q <= '0;
      fill_q <= '0;
      outp_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      outp_q <= outp_d;
      cnt_q  <= cnt_d;
    end
  end

  assign outp      = outp_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
//
// Drives two detector instances from the same stimulus: one with the default
// 8-bit counter and one with a 2-bit counter, so saturation is easy to reach.
// Expected values come from a queue-based reference model that works on the
// list of bits received since the last flush.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

  localparam int unsigned PAT_W = 5;
  localparam logic [PAT_W-1:0] DEF_PAT = 5'b10110;

  logic             clk = 1'b0;
  logic             rst;
  logic             inp;
  logic             in_valid;
  logic             load;
  logic [PAT_W-1:0] pattern;
  logic             overlap_en;
  logic             clr_cnt;
  logic             outp8, outp2;
  logic [7:0]       match_cnt8;
  logic [1:0]       match_cnt2;

  int checks = 0;
  int fails  = 0;

  // Reference model state.
  logic [PAT_W-1:0] m_pat;
  logic             m_ovl;
  logic             m_bits[$];
  logic             m_out;
  int               m_cnt8;
  int               m_cnt2;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .load(load),
    .pattern(pattern), .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .outp(outp8), .match_cnt(match_cnt8)
  );

  seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .load(load),
    .pattern(pattern), .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .outp(outp2), .match_cnt(match_cnt2)
  );

  // Counts one comparison and reports it if it fails.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advances the model by one clock edge. A match means that the last PAT_W
  // bits received since the last flush spell out the pattern.
  task automatic modelStep(input logic r, input logic v, input logic b,
                           input logic ld, input logic [PAT_W-1:0] p,
                           input logic ov, input logic cc);
    logic hit;
    hit = 1'b0;
    if (r) begin
      m_pat = DEF_PAT;
      m_ovl = 1'b1;
      m_bits.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      if (ld) begin
        m_pat = p;
        m_ovl = ov;
        m_bits.delete();
      end else if (v) begin
        m_bits.push_back(b);
        if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
        if (m_bits.size() == PAT_W) begin
          hit = 1'b1;
          for (int i = 0; i < PAT_W; i++)
            if (m_bits[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
        end
        if (hit && !m_ovl) m_bits.delete();
      end
      if (cc) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (hit) begin
        m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
        m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
      end
    end
    m_out = hit;
  endtask

  // Drives one cycle of inputs, clocks it, updates the model and checks
  // both instances just after the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic b,
                               input logic ld, input logic [PAT_W-1:0] p,
                               input logic ov, input logic cc);
    rst = r; in_valid = v; inp = b; load = ld; pattern = p;
    overlap_en = ov; clr_cnt = cc;
    @(posedge clk);
    modelStep(r, v, b, ld, p, ov, cc);
    #1;
    checkOutput("outp8", 32'(outp8), 32'(m_out));
    checkOutput("outp2", 32'(outp2), 32'(m_out));
    checkOutput("cnt8", 32'(match_cnt8), 32'(m_cnt8));
    checkOutput("cnt2", 32'(match_cnt2), 32'(m_cnt2));
  endtask

  task automatic feedBit(input logic b);
    applyStimulus(1'b0, 1'b1, b, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic cc);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, cc);
  endtask

  task automatic loadPat(input logic [PAT_W-1:0] p, input logic ov);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, p, ov, 1'b0);
  endtask

  initial begin
    logic [7:0] seq8;
    int pulses;

    rst = 1'b1; in_valid = 1'b0; inp = 1'b0; load = 1'b0;
    pattern = '0; overlap_en = 1'b0; clr_cnt = 1'b0;
    m_pat = DEF_PAT; m_ovl = 1'b1; m_out = 1'b0; m_cnt8 = 0; m_cnt2 = 0;

    // Reset defaults.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("rst_outp", 32'(outp8), 0);
    checkOutput("rst_cnt", 32'(match_cnt8), 0);

    // Test 1: default pattern in overlap mode, with matches after bits 5 and 8.
    seq8 = 8'b10110110;
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      feedBit(seq8[i]);
      pulses += int'(outp8);
    end
    checkOutput("t1_pulses", 32'(pulses), 2);
    checkOutput("t1_cnt", 32'(match_cnt8), 2);
    idle(1'b1);

    // Test 2: non-overlap mode, with a single match only.
    loadPat(5'b10110, 1'b0);
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      feedBit(seq8[i]);
      pulses += int'(outp8);
    end
    checkOutput("t2_pulses", 32'(pulses), 1);
    checkOutput("t2_cnt", 32'(match_cnt8), 1);

    // Test 3: a gap in in_valid keeps the partial match.
    loadPat(DEF_PAT, 1'b1);
    feedBit(1'b1); feedBit(1'b0); feedBit(1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      checkOutput("t3_gap", 32'(outp8), 0);
    end
    feedBit(1'b1);
    feedBit(1'b0);
    checkOutput("t3_pulse", 32'(outp8), 1);

    // Test 4: all-ones pattern, back-to-back pulses, 2-bit saturation.
    idle(1'b1);
    loadPat(5'b11111, 1'b1);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      feedBit(1'b1);
      pulses += int'(outp2);
    end
    checkOutput("t4_pulses", 32'(pulses), 5);
    checkOutput("t4_sat", 32'(match_cnt2), 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("t4_clr_cnt", 32'(match_cnt2), 0);
    checkOutput("t4_clr_outp", 32'(outp2), 1);

    // Test 5: a reset in mid-stream discards the partial match.
    loadPat(5'b00000, 1'b0);
    feedBit(1'b1); feedBit(1'b0); feedBit(1'b1); feedBit(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    feedBit(1'b0);
    checkOutput("t5_nopulse", 32'(outp8), 0);
    seq8 = 8'b00010110;
    for (int i = 4; i >= 0; i--) feedBit(seq8[i]);
    checkOutput("t5_pulse", 32'(outp8), 1);

    // Test 6: the bit in the load cycle is dropped, and the fill gate
    // protects the all-zero pattern.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      feedBit(1'b0);
      pulses += int'(outp8);
    end
    checkOutput("t6_gate", 32'(pulses), 0);
    feedBit(1'b0);
    checkOutput("t6_pulse", 32'(outp8), 1);

    // Random phase. Short loads keep matches frequent. The model checks
    // every cycle.
    for (int n = 0; n < 3000; n++) begin
      logic r, v, b, ld, ov, cc;
      logic [PAT_W-1:0] p;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 39) == 0);
      cc = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom);
      ov = 1'($urandom);
      p  = ($urandom_range(0, 3) == 0) ? 5'b11111 : PAT_W'($urandom);
      applyStimulus(r, v, b, ld, p, ov, cc);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
